// File: rtl/pwm_generator_pkg.sv
// Shared constants and helpers for the PWM generator and its prescaler.
package pwm_generator_pkg;

    // Default counter width and clocks per counter step
    localparam int PWM_DEFAULT_WIDTH   = 8;
    localparam int PWM_DEFAULT_CLK_DIV = 1;

    // Prescaler register width: max(1, clog2(clk_div)); a divide-by-1 still needs one bit
    function automatic int presc_width(input int clk_div);
        int w;
        w = $clog2(clk_div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..CLK_DIV-1 and raises a one-cycle tick on the last count.
// CLK_DIV=1 keeps the count at 0 so the tick is asserted every clock.
module pwm_prescaler
    import pwm_generator_pkg::*;
#(
    parameter int CLK_DIV = PWM_DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int            PW   = presc_width(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] r_presc;

    assign tick = (r_presc == LAST);

    // Step counter: restart after the tick or whenever the owner holds it cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (clear || tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + ONE;
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// PWM generator: prescaled frame counter with registered compare output.
// Frame is period+1 counter steps; output is high while the counter is below duty.
// Optional macro PWM_GENERATOR_SHADOW_EN: duty/period are captured into shadow
// registers only while disabled or at a frame wrap, so mid-frame updates never
// produce a partial frame. Without it the live inputs are used directly.
module pwm_generator
    import pwm_generator_pkg::*;
#(
    parameter int WIDTH   = PWM_DEFAULT_WIDTH,
    parameter int CLK_DIV = PWM_DEFAULT_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] period,
    output logic             pwm_out
);

    logic             w_tick;
    logic             w_presc_clear;
    logic             w_at_end;
    logic [WIDTH-1:0] w_duty_eff;
    logic [WIDTH-1:0] w_period_eff;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] r_cnt;
    logic             r_pwm;

    // Prescaler only runs while enabled so every enable starts on a fresh step
    assign w_presc_clear = ~enable;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_presc_clear),
        .tick  (w_tick)
    );

    // ">=" rather than "==" so a counter stranded above a shrunken period still wraps
    assign w_at_end = (r_cnt >= w_period_eff);

`ifdef PWM_GENERATOR_SHADOW_EN
    logic             w_wrap;
    logic [WIDTH-1:0] r_duty_sh;
    logic [WIDTH-1:0] r_period_sh;

    assign w_wrap = enable && w_tick && w_at_end;

    // Capture new settings only while idle or on the step that starts a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_sh   <= '0;
            r_period_sh <= '0;
        end else if (!enable || w_wrap) begin
            r_duty_sh   <= duty;
            r_period_sh <= period;
        end
    end

    assign w_duty_eff   = r_duty_sh;
    assign w_period_eff = r_period_sh;
`else
    assign w_duty_eff   = duty;
    assign w_period_eff = period;
`endif

    // Next counter value: cleared when disabled, advances or wraps on each tick
    always_comb begin
        w_cnt_next = r_cnt;
        if (!enable) begin
            w_cnt_next = '0;
        end else if (w_tick) begin
            w_cnt_next = w_at_end ? '0 : (r_cnt + WIDTH'(1));
        end
    end

    // Frame counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Registered compare output; the async reset drops it low without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= enable && (r_cnt < w_duty_eff);
        end
    end

    assign pwm_out = r_pwm;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: one instance at CLK_DIV=1, one at CLK_DIV=4.
// Expected high counts are pushed to a scoreboard queue when stimulus is applied
// and popped when the measured window of DUT output completes.
module tb_pwm_generator;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en1;
    logic       en4;
    logic [7:0] duty1;
    logic [7:0] period1;
    logic [7:0] duty4;
    logic [7:0] period4;
    logic       pwm1;
    logic       pwm4;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

`ifdef PWM_GENERATOR_SHADOW_EN
    localparam int WRAP_CLKS = 224;
`else
    localparam int WRAP_CLKS = 4;
`endif

    always #5 clk = ~clk;

    pwm_generator #(.WIDTH(8), .CLK_DIV(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (en1),
        .duty    (duty1),
        .period  (period1),
        .pwm_out (pwm1)
    );

    pwm_generator #(.WIDTH(8), .CLK_DIV(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (en4),
        .duty    (duty4),
        .period  (period4),
        .pwm_out (pwm4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s got %0d", tag, got);
        end
    endtask

    // Single-sample transaction through the scoreboard
    task automatic sample(input string tag, input logic [31:0] got, input int exp);
        exp_q.push_back(exp);
        check_eq(tag, got, exp_q.pop_front());
    endtask

    // Count high samples over nclk clocks and compare with the queued expectation
    task automatic count_high(input string tag, input bit sel4, input int nclk, input int exp);
        int  hi;
        logic s;
        hi = 0;
        exp_q.push_back(exp);
        for (int i = 0; i < nclk; i++) begin
            @(negedge clk);
            s = sel4 ? pwm4 : pwm1;
            if (s === 1'b1) hi++;
        end
        check_eq(tag, hi, exp_q.pop_front());
    endtask

    // Bounded wait for the CLK_DIV=1 output to be high
    task automatic wait_high1(input string tag);
        int k;
        k = 0;
        while (pwm1 !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (pwm1 !== 1'b1) check_eq(tag, pwm1, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int duties[4];
        int ramp[11];
        int k;
        duties = '{0, 25, 75, 100};
        ramp   = '{0, 51, 102, 153, 204, 255, 204, 153, 102, 51, 0};
        en1 = 1'b0; en4 = 1'b0;
        duty1 = '0; period1 = '0; duty4 = '0; period4 = '0;

        // Reset asserted before any clock edge: output must clear asynchronously
        #2 rst_n = 1'b0;
        #1;
        sample("rst_async1", pwm1, 0);
        sample("rst_async4", pwm4, 0);
        repeat (2) @(negedge clk);
        sample("rst_hold1", pwm1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        sample("rel_dis1", pwm1, 0);
        sample("rel_dis4", pwm4, 0);

        // period=99, duty sweep
        period1 = 8'd99; duty1 = 8'd50;
        @(negedge clk);
        en1 = 1'b1;
        repeat (2) @(negedge clk);
        count_high("p99_d50", 0, 100, 50);
        foreach (duties[i]) begin
            duty1 = 8'(duties[i]);
            repeat (110) @(negedge clk);
            count_high($sformatf("p99_d%0d", duties[i]), 0, 100, duties[i]);
        end

        // Disable while high, then re-enable: frame restarts at cnt=0
        duty1 = 8'd50;
        repeat (110) @(negedge clk);
        wait_high1("dis_wait");
        en1 = 1'b0;
        @(negedge clk);
        sample("dis_next", pwm1, 0);
        count_high("dis_hold", 0, 50, 0);
        en1 = 1'b1;
        count_high("reen_first50", 0, 50, 50);
        count_high("reen_next50", 0, 50, 0);

        // Reset mid-frame while output high: immediate low without a clock edge
        wait_high1("rstmid_wait");
        #2 rst_n = 1'b0;
        #1;
        sample("rst_mid", pwm1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // period=0 corner
        period1 = 8'd0; duty1 = 8'd1;
        repeat (110) @(negedge clk);
        count_high("p0_d1", 0, 20, 20);
        duty1 = 8'd0;
        repeat (5) @(negedge clk);
        count_high("p0_d0", 0, 20, 0);

        // Full-range period, duty ramp up and down
        period1 = 8'd255;
        foreach (ramp[i]) begin
            duty1 = 8'(ramp[i]);
            repeat (260) @(negedge clk);
            count_high($sformatf("ramp_d%0d", ramp[i]), 0, 256, ramp[i]);
        end
        en1 = 1'b0;

        // CLK_DIV=4: period=9 duty=3 -> 40-clock frame, 12 high
        period4 = 8'd9; duty4 = 8'd3;
        repeat (2) @(negedge clk);
        en4 = 1'b1;
        repeat (50) @(negedge clk);
        count_high("div4_p9_d3", 1, 40, 12);

        // Shrink period from 255 to 5 while cnt=200: counter must wrap on the next tick
        en4 = 1'b0;
        period4 = 8'd255; duty4 = 8'd3;
        repeat (2) @(negedge clk);
        en4 = 1'b1;
        repeat (801) @(negedge clk);
        sample("div4_low_at200", pwm4, 0);
        period4 = 8'd5;
        k = 0;
        while (pwm4 !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        sample("div4_wrap_clks", k, WRAP_CLKS);
        repeat (30) @(negedge clk);
        count_high("div4_p5_d3", 1, 24, 12);
        en4 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
